// File: rtl/cnn_pkg.sv
// Shared definitions for the float16 convolution/FC array result path.
package cnn_pkg;

  localparam int PARA_X        = 3;
  localparam int PARA_Y        = 3;
  localparam int DATA_WIDTH    = 16;
  localparam int ADDR_WIDTH    = 16;
  localparam int FP16_SIGN_BIT = DATA_WIDTH - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } wr_state_e;

  // ReLU on a float16 bit pattern. Any word with the sign bit set is
  // flushed to +0, which deliberately includes -0 and negative NaNs.
  function automatic logic [DATA_WIDTH-1:0] relu_fp16(
    input logic [DATA_WIDTH-1:0] word,
    input logic                  en
  );
    if (en && word[FP16_SIGN_BIT]) begin
      relu_fp16 = {DATA_WIDTH{1'b0}};
    end else begin
      relu_fp16 = word;
    end
  endfunction

endpackage

// File: rtl/conv_result_addr_gen.sv
// 2-D write address generator: walks x across a row, then steps the row
// base by the latched stride. Addresses wrap modulo 2^ADDR_WIDTH.
module conv_result_addr_gen #(
  parameter int PARA_X     = cnn_pkg::PARA_X,
  parameter int PARA_Y     = cnn_pkg::PARA_Y,
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
  parameter int IDX_W      = $clog2(PARA_X * PARA_Y)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last,
  output logic [IDX_W-1:0]      index
);

  localparam int X_W = (PARA_X > 1) ? $clog2(PARA_X) : 1;
  localparam int Y_W = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;

  logic [X_W-1:0]        x_r;
  logic [Y_W-1:0]        y_r;
  logic [ADDR_WIDTH-1:0] row_addr_r;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic                  row_end_s;

  assign row_end_s = (x_r == X_W'(PARA_X - 1));

  // Counter/row-base update; a fresh load has priority over an advance so
  // a vector captured on the last-accept cycle starts cleanly at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r        <= {X_W{1'b0}};
      y_r        <= {Y_W{1'b0}};
      row_addr_r <= {ADDR_WIDTH{1'b0}};
      stride_r   <= {ADDR_WIDTH{1'b0}};
    end else if (load) begin
      x_r        <= {X_W{1'b0}};
      y_r        <= {Y_W{1'b0}};
      row_addr_r <= base;
      stride_r   <= stride;
    end else if (advance) begin
      if (row_end_s) begin
        x_r        <= {X_W{1'b0}};
        y_r        <= y_r + Y_W'(1);
        row_addr_r <= row_addr_r + stride_r;
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  // Address, element index and last-element flag from the current position.
  always_comb begin
    addr  = row_addr_r + ADDR_WIDTH'(x_r);
    index = IDX_W'(y_r) * IDX_W'(PARA_X) + IDX_W'(x_r);
    last  = row_end_s && (y_r == Y_W'(PARA_Y - 1));
  end

endmodule

// File: rtl/conv_result_writer.sv
// Captures a PARA_X x PARA_Y float16 result vector from the array, applies
// optional ReLU, and streams it to the feature-map write port one word per
// handshake. Reports busy, a done pulse and a sticky dropped-vector flag.
module conv_result_writer #(
  parameter int PARA_X     = cnn_pkg::PARA_X,
  parameter int PARA_Y     = cnn_pkg::PARA_Y,
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                result_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] result_buffer,
  input  logic                                relu_en,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ADDR_WIDTH-1:0]               row_stride,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [ADDR_WIDTH-1:0]               wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow
);

  import cnn_pkg::*;

  localparam int NUM   = PARA_X * PARA_Y;
  localparam int IDX_W = $clog2(NUM);

  wr_state_e             state_r;
  wr_state_e             next_state_s;
  logic                  ready_q_r;
  logic                  cap_s;
  logic                  load_s;
  logic                  advance_s;
  logic                  done_set_s;
  logic                  ovf_set_s;
  logic                  done_r;
  logic                  overflow_r;
  logic [DATA_WIDTH-1:0] elem_r [NUM];
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  last_s;
  logic [IDX_W-1:0]      index_s;

  assign cap_s = result_ready & ~ready_q_r;

  // Delayed copy of result_ready for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q_r <= 1'b0;
    end else begin
      ready_q_r <= result_ready;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode. In SEND wr_valid is always high, so a
  // handshake is simply wr_ready. An edge coinciding with the final accept
  // is taken as the next vector; any other edge while busy is dropped.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    done_set_s   = 1'b0;
    ovf_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cap_s) begin
          load_s       = 1'b1;
          next_state_s = SEND;
        end else begin
          next_state_s = IDLE;
        end
      end
      SEND: begin
        if (wr_ready) begin
          advance_s = 1'b1;
          if (last_s) begin
            done_set_s = 1'b1;
            if (cap_s) begin
              load_s       = 1'b1;
              next_state_s = SEND;
            end else begin
              next_state_s = IDLE;
            end
          end else begin
            ovf_set_s = cap_s;
          end
        end else begin
          ovf_set_s = cap_s;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Capture register: ReLU is folded in at latch time so the stream path
  // only has to select a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        elem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (load_s) begin
      for (int i = 0; i < NUM; i++) begin
        elem_r[i] <= relu_fp16(result_buffer[i*DATA_WIDTH +: DATA_WIDTH], relu_en);
      end
    end
  end

  // Completion pulse and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r     <= done_set_s;
      overflow_r <= overflow_r | ovf_set_s;
    end
  end

  conv_result_addr_gen #(
    .PARA_X     (PARA_X),
    .PARA_Y     (PARA_Y),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .base    (base_addr),
    .stride  (row_stride),
    .advance (advance_s),
    .addr    (addr_s),
    .last    (last_s),
    .index   (index_s)
  );

  // Output drive: the write port is held at zero whenever no vector is
  // being streamed, so IDLE looks identical to the reset state.
  always_comb begin
    busy     = (state_r == SEND);
    wr_valid = busy;
    done     = done_r;
    overflow = overflow_r;
    if (busy) begin
      wr_addr = addr_s;
      wr_data = elem_r[index_s];
    end else begin
      wr_addr = {ADDR_WIDTH{1'b0}};
      wr_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: stream order and addressing, ReLU,
// backpressure, overflow, back-to-back capture with address wrap, reset abort.
module tb_conv_result_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         result_ready;
  logic [143:0] result_buffer;
  logic         relu_en;
  logic [15:0]  base_addr;
  logic [15:0]  row_stride;
  logic         wr_valid;
  logic         wr_ready;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_data;
  logic         busy;
  logic         done;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] vec [9];
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  conv_result_writer dut (
    .clk           (clk),
    .rst           (rst),
    .result_ready  (result_ready),
    .result_buffer (result_buffer),
    .relu_en       (relu_en),
    .base_addr     (base_addr),
    .row_stride    (row_stride),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_vec();
    for (int i = 0; i < 9; i++) result_buffer[i*16 +: 16] = vec[i];
  endtask

  task automatic put_junk();
    result_buffer = {9{16'h7bad}};
  endtask

  // One-cycle result_ready pulse; side inputs are scrambled afterwards to
  // show that only the capture-cycle values matter.
  task automatic capture(input logic [15:0] b, input logic [15:0] s, input logic r);
    put_vec();
    base_addr    = b;
    row_stride   = s;
    relu_en      = r;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    put_junk();
    base_addr    = 16'h5555;
    row_stride   = 16'h0aaa;
    relu_en      = ~r;
  endtask

  // Streams one vector, checking every presented word against the model.
  // mode 0: wr_ready held 1; mode 1: repeating 1,0,0,1,0,1 pattern.
  // cap_k >= 0 raises a new edge on the cycle accepting word cap_k.
  task automatic drain(input logic [15:0] b, input logic [15:0] s, input logic r,
                       input int mode, input int cap_k,
                       input logic [15:0] b2, input logic [15:0] s2);
    int          k = 0;
    int          cyc = 0;
    logic        rdy;
    logic        capped;
    logic [15:0] ea;
    logic [15:0] ed;
    while (k < 9 && cyc < 100) begin
      ea = b + 16'(k / 3) * s + 16'(k % 3);
      ed = (r && vec[k][15]) ? 16'h0000 : vec[k];
      check("wr_valid", {31'd0, wr_valid}, 32'd1);
      check("busy", {31'd0, busy}, 32'd1);
      check($sformatf("addr[%0d]", k), {16'd0, wr_addr}, {16'd0, ea});
      check($sformatf("data[%0d]", k), {16'd0, wr_data}, {16'd0, ed});
      rdy      = (mode == 0) ? 1'b1 : logic'(pat[cyc % 6]);
      wr_ready = rdy;
      capped   = 1'b0;
      if (rdy && k == cap_k) begin
        put_vec();
        base_addr    = b2;
        row_stride   = s2;
        relu_en      = 1'b0;
        result_ready = 1'b1;
        capped       = 1'b1;
      end
      step();
      cyc++;
      if (capped) begin
        result_ready = 1'b0;
        put_junk();
        base_addr    = 16'h5555;
      end
      if (rdy) k++;
      if (k == 9) check("done_pulse", {31'd0, done}, 32'd1);
      else        check("done_low", {31'd0, done}, 32'd0);
    end
    if (k != 9) check("stream_timeout", k, 32'd9);
    wr_ready = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_valid"}, {31'd0, wr_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'hc000,
            16'h0000, 16'h8000, 16'h4dc0, 16'h4f80};
    rst = 1'b1; result_ready = 1'b0; relu_en = 1'b0; wr_ready = 1'b0;
    base_addr = 16'h0; row_stride = 16'h0; put_junk();
    step(); step();
    check("rst_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_addr", {16'd0, wr_addr}, 32'd0);
    check("rst_data", {16'd0, wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    step();
    idle_checks("idle0");

    // Basic stream, ReLU off
    capture(16'h0100, 16'h0020, 1'b0);
    drain(16'h0100, 16'h0020, 1'b0, 0, -1, 16'h0, 16'h0);
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    step();
    idle_checks("basic_end");

    // ReLU on: c000 and 8000 must come out as 0000
    capture(16'h0100, 16'h0020, 1'b1);
    drain(16'h0100, 16'h0020, 1'b1, 0, -1, 16'h0, 16'h0);
    step();
    idle_checks("relu_end");

    // Backpressure
    capture(16'h0400, 16'h0008, 1'b0);
    drain(16'h0400, 16'h0008, 1'b0, 1, -1, 16'h0, 16'h0);
    wr_ready = 1'b1;
    step();
    idle_checks("bp_end1");
    step();
    idle_checks("bp_end2");
    wr_ready = 1'b0;

    // Back-to-back capture on the last accept, second vector wraps
    capture(16'h0100, 16'h0020, 1'b0);
    drain(16'h0100, 16'h0020, 1'b0, 0, 8, 16'hffff, 16'h0001);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    drain(16'hffff, 16'h0001, 1'b0, 0, -1, 16'h0, 16'h0);
    check("b2b_no_ovf", {31'd0, overflow}, 32'd0);
    step();
    idle_checks("b2b_end");

    // Overflow: edge at the 3rd accept is dropped
    capture(16'h0100, 16'h0020, 1'b0);
    drain(16'h0100, 16'h0020, 1'b0, 0, 2, 16'h0800, 16'h0100);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    wr_ready = 1'b1;
    step();
    idle_checks("ovf_end1");
    step();
    idle_checks("ovf_end2");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    wr_ready = 1'b0;

    // Reset mid-SEND after 4 accepts
    capture(16'h0200, 16'h0010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pre_rst_addr[%0d]", k), {16'd0, wr_addr},
            {16'd0, 16'h0200 + 16'(k / 3) * 16'h0010 + 16'(k % 3)});
      wr_ready = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_checks("mid_rst");
    check("mid_rst_addr", {16'd0, wr_addr}, 32'd0);
    check("mid_rst_data", {16'd0, wr_data}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    step();
    idle_checks("mid_rst2");
    wr_ready = 1'b0;
    capture(16'h0300, 16'h0040, 1'b0);
    drain(16'h0300, 16'h0040, 1'b0, 0, -1, 16'h0, 16'h0);
    step();
    idle_checks("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Downstream stage of the float16 parallel convolution/FC array. Captures the PARA_X×PARA_Y result vector when the array raises `result_ready` and optionally applies ReLU. It then streams the words one per handshake to the feature-map write port, generating 2-D addresses (base + row stride). Reports busy, completion and dropped-result overflow to the layer controller.

## Interface
- PARA_X, 3, output columns per result vector
- PARA_Y, 3, output rows per result vector
- DATA_WIDTH, 16, float16 word width
- ADDR_WIDTH, 16, write-port word address width

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- result_ready  input  1  array result valid; level, capture on 0→1 edge
- result_buffer  input  PARA_X*PARA_Y*DATA_WIDTH  element i = y*PARA_X+x at bits [i*DATA_WIDTH +: DATA_WIDTH]
- relu_en  input  1  1: clamp negative results to 0
- base_addr  input  ADDR_WIDTH  address of element (0,0)
- row_stride  input  ADDR_WIDTH  address step between rows
- wr_valid  output  1  write word valid
- wr_ready  input  1  write port accepts word
- wr_addr  output  ADDR_WIDTH  write address
- wr_data  output  DATA_WIDTH  write data
- busy  output  1  vector held / streaming
- done  output  1  one-cycle pulse, vector fully written
- overflow  output  1  sticky, an edge arrived while busy and was dropped

## Operation
- Edge detect: `cap = result_ready & ~ready_q`; `ready_q` resets to 0.
- States: IDLE, SEND. `busy` = (state == SEND).
- IDLE + cap → latch all elements, `base_addr`, `row_stride` and `relu_en`. Set x=0, y=0, row_addr=base_addr and go to SEND.
- ReLU is applied at latch time. With relu_en=1, any element with bit DATA_WIDTH-1 set becomes 16'h0000; this includes -0 and negative NaN. Other values pass unchanged.
- SEND: wr_data = element(x,y) and wr_addr = row_addr + x. On each `wr_valid & wr_ready`:
  - x < PARA_X-1 → x++.
  - Otherwise x=0, y++, row_addr += row_stride.
- Last element (x=PARA_X-1, y=PARA_Y-1) accepted → done=1 on the next cycle and return to IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- cap while in SEND and not on the last-accept cycle → vector dropped, overflow set to 1. Overflow clears only on rst.
- cap on the same cycle as the last accept → new vector latched and state stays in SEND. done still pulses and there is no overflow.
- Port inputs other than result_ready/result_buffer are ignored outside the capture cycle.

## Timing
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, busy 0, done 0, overflow 0, state IDLE.
- rst mid-SEND aborts the vector with no done pulse. Outputs return to reset values the next cycle.
- cap sampled at edge N → wr_valid=1, first word presented after edge N.
- With wr_ready held 1, words are accepted at edges N+1…N+PARA_X*PARA_Y, and done is high for the cycle after the last accept.
- While wr_valid & ~wr_ready, wr_addr and wr_data stay stable and wr_valid does not drop.
- wr_valid=0 in IDLE.

## Structure
- Shared package `cnn_pkg`: PARA_X, PARA_Y, DATA_WIDTH, FP16_SIGN_BIT, state enum {IDLE, SEND}.
- One sub-module: `conv_result_addr_gen`. It holds the x/y counters and row_addr register, with inputs load/base/stride/advance and outputs addr/last.
- The capture register, ReLU, FSM and flags stay in the top module.

## Test plan
- Basic stream, relu off:
  - Stimulus: elements 0..8 = 3c00,4000,4200,4400,c000,0000,8000,4dc0,4f80; base 0x0100; stride 0x0020; wr_ready=1.
  - Response: addrs 0100,0101,0102,0120,0121,0122,0140,0141,0142 with data in that order; done one cycle after the 9th accept; busy low again.
- ReLU on, same vector → c000 and 8000 written as 0000; all other words unchanged.
- Backpressure:
  - Stimulus: wr_ready pattern 1,0,0,1,0,1,… .
  - Response: exactly 9 accepts, no duplicate or skipped address, data/addr stable during stalls.
- Overflow:
  - Stimulus: second result_ready edge at the 3rd accept.
  - Response: overflow=1 (stays 1), only the first vector is written, done pulses once.
- Back-to-back and wrap:
  - Stimulus: edge on the last-accept cycle, second vector base 0xFFFF, stride 0x0001.
  - Response: busy stays high; the second vector's addrs start FFFF,0000,0001,0000,…; done pulses twice.
- Reset mid-SEND:
  - Stimulus: rst after 4 accepts.
  - Response: the next cycle wr_valid=0 and busy=0; no done pulse; a following edge streams a full vector from (0,0).
